// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle MIPS-style datapath. Sequences each
// instruction through fetch, decode and the per-class execute states. It
// drives the datapath control strobes and counts retired instructions.
//
// Optional feature macro: MIPS_JUMP_EN
//   defined   -> opcode 000010 (j) is executed through the JUMP state.
//   undefined -> opcode 000010 is treated as an illegal opcode.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   opcode[5:0]  : instruction[31:26] from the instruction register
//   zero         : ALU zero flag (acts in the datapath through pcwritecond)
//   mem_ready    : memory completes the current access this cycle
//   pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
//   irwrite, regdest, regwrite, alusrca : 1-bit datapath controls
//   alusrcb, aluop, pcsource            : 2-bit datapath selects
//   illegal      : high during the DECODE cycle of an unknown opcode
//   state[3:0]   : current FSM state (debug)
//   retired      : count of completed instructions, wraps at all-ones
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                irwrite,
    output logic                regdest,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsource,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MIPS_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t              state_reg;
    state_t              state_next;
    logic [RETIRE_W-1:0] retired_reg;
    logic                retire_next;

    // The branch decision is made in the datapath: pcwritecond is gated with
    // zero there, so the FSM sequence does not depend on the flag.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire_next) begin
                retired_reg <= retired_reg + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        state_next  = FETCH;
        retire_next = 1'b0;
        illegal     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;

        case (state_reg)
            FETCH: begin
                // IR and PC+4 are only captured on the cycle memory delivers.
                memread    = 1'b1;
                alusrcb    = 2'b01;
                irwrite    = mem_ready;
                pcwrite    = mem_ready;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode decodes.
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MIPS_JUMP_EN
                    OP_J:         state_next = JUMP;
`endif
                    default: begin
                        state_next = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread    = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite    = 1'b1;
                memtoreg    = 1'b1;
                retire_next = 1'b1;
                state_next  = FETCH;
            end
            MEMWR: begin
                // Write strobe stays up for the whole stall.
                memwrite    = 1'b1;
                iord        = 1'b1;
                retire_next = mem_ready;
                state_next  = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                regwrite    = 1'b1;
                regdest     = 1'b1;
                retire_next = 1'b1;
                state_next  = FETCH;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                retire_next = 1'b1;
                state_next  = FETCH;
            end
`ifdef MIPS_JUMP_EN
            JUMP: begin
                pcwrite     = 1'b1;
                pcsource    = 2'b10;
                retire_next = 1'b1;
                state_next  = FETCH;
            end
`endif
            default: begin
                // Unused encodings (and JUMP when jumps are disabled) recover.
                state_next = FETCH;
            end
        endcase
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control (RETIRE_W = 4 so the wrap case is
// short). Each instruction task pushes the expected per-cycle state, control
// word, illegal flag and retired count. It then drives the cycles, and every
// sample pops one record and compares it against the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int RW = 4;

    // Expected control word packing:
    // [15]pcwrite [14]pcwritecond [13]iord [12]memread [11]memwrite
    // [10]memtoreg [9]irwrite [8]regdest [7]regwrite [6]alusrca
    // [5:4]alusrcb [3:2]aluop [1:0]pcsource
    localparam logic [15:0] C_FETCH_RDY  = 16'h9210; // pcwrite,memread,irwrite,alusrcb=01
    localparam logic [15:0] C_FETCH_WAIT = 16'h1010; // memread,alusrcb=01
    localparam logic [15:0] C_DECODE     = 16'h0030; // alusrcb=11
    localparam logic [15:0] C_MEMADR     = 16'h0060; // alusrca,alusrcb=10
    localparam logic [15:0] C_MEMRD      = 16'h3000; // iord,memread
    localparam logic [15:0] C_MEMWB      = 16'h0480; // memtoreg,regwrite
    localparam logic [15:0] C_MEMWR      = 16'h2800; // iord,memwrite
    localparam logic [15:0] C_EXEC       = 16'h0048; // alusrca,aluop=10
    localparam logic [15:0] C_RWB        = 16'h0180; // regdest,regwrite
    localparam logic [15:0] C_BRANCH     = 16'h4045; // pcwritecond,alusrca,aluop=01,pcsource=01
`ifdef MIPS_JUMP_EN
    localparam logic [15:0] C_JUMP       = 16'h8002; // pcwrite,pcsource=10
`endif

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic          clk;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pcwrite, pcwritecond, iord, memread, memwrite;
    logic          memtoreg, irwrite, regdest, regwrite, alusrca;
    logic [1:0]    alusrcb, aluop, pcsource;
    logic          illegal;
    logic [3:0]    state;
    logic [RW-1:0] retired;
    logic [15:0]   ctrl_obs;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .irwrite     (irwrite),
        .regdest     (regdest),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .aluop       (aluop),
        .pcsource    (pcsource),
        .illegal     (illegal),
        .state       (state),
        .retired     (retired)
    );

    assign ctrl_obs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                       irwrite, regdest, regwrite, alusrca, alusrcb, aluop, pcsource};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [3:0]    st;
        logic [15:0]   ctrl;
        logic          ill;
        logic [RW-1:0] ret;
    } exp_t;

    exp_t          sb_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [RW-1:0] ret_model   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] st, input logic [15:0] ctrl,
                        input logic ill);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = ctrl;
        e.ill  = ill;
        e.ret  = ret_model;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".state"},   32'(state),    32'(e.st));
            check({e.tag, ".ctrl"},    32'(ctrl_obs), 32'(e.ctrl));
            check({e.tag, ".illegal"}, 32'(illegal),  32'(e.ill));
            check({e.tag, ".retired"}, 32'(retired),  32'(e.ret));
        end
    endtask

    // Called at a falling edge: drive, settle, compare, advance one cycle.
    task automatic apply(input logic [5:0] op, input logic mr, input logic z);
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic retire_one();
        ret_model = ret_model + RW'(1);
    endtask

    task automatic do_lw();
        push("lw.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("lw.d", 4'd1, C_DECODE,    1'b0);
        push("lw.a", 4'd2, C_MEMADR,    1'b0);
        push("lw.r", 4'd3, C_MEMRD,     1'b0);
        push("lw.w", 4'd4, C_MEMWB,     1'b0);
        for (int i = 0; i < 5; i++) apply(OP_LW, 1'b1, 1'b0);
        retire_one();
        $display("txn lw          retired_exp=%0d", ret_model);
    endtask

    task automatic do_sw(input int stall);
        push("sw.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("sw.d", 4'd1, C_DECODE,    1'b0);
        push("sw.a", 4'd2, C_MEMADR,    1'b0);
        for (int i = 0; i <= stall; i++) push("sw.m", 4'd5, C_MEMWR, 1'b0);
        for (int i = 0; i < 3; i++) apply(OP_SW, 1'b1, 1'b0);
        for (int i = 0; i < stall; i++) apply(OP_SW, 1'b0, 1'b0);
        apply(OP_SW, 1'b1, 1'b0);
        retire_one();
        $display("txn sw stall=%0d  retired_exp=%0d", stall, ret_model);
    endtask

    task automatic do_fetch_stall(input int n);
        for (int i = 0; i < n; i++) push("fstall", 4'd0, C_FETCH_WAIT, 1'b0);
        for (int i = 0; i < n; i++) apply(OP_R, 1'b0, 1'b0);
        $display("txn fetch stall=%0d", n);
    endtask

    task automatic do_beq();
        push("beq.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("beq.d", 4'd1, C_DECODE,    1'b0);
        push("beq.b", 4'd8, C_BRANCH,    1'b0);
        for (int i = 0; i < 3; i++) apply(OP_BEQ, 1'b1, 1'b1);
        retire_one();
        $display("txn beq         retired_exp=%0d", ret_model);
    endtask

    task automatic do_rtype(input bit quiet);
        push("r.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("r.d", 4'd1, C_DECODE,    1'b0);
        push("r.e", 4'd6, C_EXEC,      1'b0);
        push("r.w", 4'd7, C_RWB,       1'b0);
        for (int i = 0; i < 4; i++) apply(OP_R, 1'b1, 1'b0);
        retire_one();
        if (!quiet) $display("txn rtype       retired_exp=%0d", ret_model);
    endtask

    task automatic do_illegal(input logic [5:0] op);
        push("ill.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("ill.d", 4'd1, C_DECODE,    1'b1);
        for (int i = 0; i < 2; i++) apply(op, 1'b1, 1'b0);
        $display("txn illegal op=%b retired_exp=%0d", op, ret_model);
    endtask

    task automatic do_jump();
`ifdef MIPS_JUMP_EN
        push("j.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("j.d", 4'd1, C_DECODE,    1'b0);
        push("j.j", 4'd9, C_JUMP,      1'b0);
        for (int i = 0; i < 3; i++) apply(OP_J, 1'b1, 1'b0);
        retire_one();
        $display("txn jump        retired_exp=%0d", ret_model);
`else
        do_illegal(OP_J);
`endif
    endtask

    // Load stalled in MEMRD, then reset asserted between clock edges.
    task automatic do_reset_mid_memrd();
        push("rlw.f", 4'd0, C_FETCH_RDY, 1'b0);
        push("rlw.d", 4'd1, C_DECODE,    1'b0);
        push("rlw.a", 4'd2, C_MEMADR,    1'b0);
        for (int i = 0; i < 3; i++) apply(OP_LW, 1'b1, 1'b0);
        push("rlw.r", 4'd3, C_MEMRD, 1'b0);
        opcode    = OP_LW;
        mem_ready = 1'b0;
        #1;
        sample();
        #2;
        rst_n     = 1'b0;
        ret_model = '0;
        #1;
        push("rst_async", 4'd0, C_FETCH_WAIT, 1'b0);
        sample();
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset mid-MEMRD retired_exp=%0d", ret_model);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #1;
        push("reset", 4'd0, C_FETCH_WAIT, 1'b0);
        sample();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_lw();
        do_fetch_stall(2);
        do_sw(3);
        do_beq();
        do_rtype(1'b0);
        do_illegal(OP_BAD);
        do_jump();
        do_lw();
        do_reset_mid_memrd();

        for (int i = 0; i < 16; i++) do_rtype(1'b1);
        $display("txn 16x rtype   retired_exp=%0d", ret_model);

        push("wrap", 4'd0, C_FETCH_WAIT, 1'b0);
        opcode    = OP_R;
        mem_ready = 1'b0;
        #1;
        sample();
        check("wrap.zero", 32'(retired), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter RETIRE_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6, instruc[31:26] taken from the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-007 SHALL have these 1-bit outputs: pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regdest, regwrite, alusrca.
REQ-008 SHALL have these 2-bit outputs: alusrcb, aluop, pcsource.
REQ-009 SHALL have port illegal, output, 1, one-cycle pulse on an unknown opcode.
REQ-010 SHALL have port state, output, 4, current FSM state for debug.
REQ-011 SHALL have port retired, output, RETIRE_W, count of completed instructions.

Function
REQ-012 SHALL implement the state encoding FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; values 10-15 go to FETCH on the next edge.
REQ-013 SHALL, in FETCH, assert memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready; go to DECODE when mem_ready=1, otherwise hold FETCH.
REQ-014 SHALL, in DECODE, assert alusrca=0, alusrcb=11, aluop=00, then branch on opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP (JUMP only per REQ-026), any other->FETCH with illegal=1 for that cycle.
REQ-015 SHALL, in MEMADR, assert alusrca=1, alusrcb=10, aluop=00; go to MEMRD on lw, MEMWR on sw.
REQ-016 SHALL, in MEMRD, assert memread=1, iord=1; go to MEMWB when mem_ready=1, otherwise hold.
REQ-017 SHALL, in MEMWB, assert regwrite=1, memtoreg=1, regdest=0; go to FETCH.
REQ-018 SHALL, in MEMWR, assert memwrite=1, iord=1 for every cycle in the state; go to FETCH when mem_ready=1.
REQ-019 SHALL, in EXEC, assert alusrca=1, alusrcb=00, aluop=10; go to RWB.
REQ-020 SHALL, in RWB, assert regwrite=1, regdest=1, memtoreg=0; go to FETCH.
REQ-021 SHALL, in BRANCH, assert alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; go to FETCH regardless of zero.
REQ-022 SHALL drive every output not listed for a state to 0; all outputs are combinational from state, with mem_ready additionally feeding irwrite/pcwrite in FETCH.
REQ-023 SHALL increment retired by 1 on the edge leaving MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH or JUMP; the counter wraps from all-ones to 0; illegal opcodes are not counted.
REQ-024 SHALL leave opcode, zero and mem_ready unsampled in states that do not use them; mem_ready held 0 stalls indefinitely with no timeout.

Reset
REQ-025 SHALL, while rst_n=0, force state=FETCH, retired=0 and illegal=0 asynchronously; outputs then follow FETCH decoding (memread=1, alusrcb=01, irwrite=pcwrite=mem_ready), and an access in progress is abandoned.

Configuration
REQ-026 SHALL honour macro MIPS_JUMP_EN: when defined, opcode 000010 goes DECODE->JUMP, JUMP asserts pcwrite=1, pcsource=10, then goes to FETCH and counts as retired; when undefined, state 9 is unreachable and opcode 000010 is illegal per REQ-014.

Verification
REQ-027 Bench SHALL check reset: rst_n=0 mid-MEMRD -> state=0, retired=0 immediately, without waiting for a clock edge.
REQ-028 Bench SHALL check lw with mem_ready=1 throughout -> states 0,1,2,3,4,0 over 5 cycles, regwrite=memtoreg=1 in cycle 5, retired=1.
REQ-029 Bench SHALL check sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH, retired +1.
REQ-030 Bench SHALL check beq with zero=1 -> in state 8, pcwritecond=1, pcsource=01, aluop=01; R-type -> state 6 aluop=10, state 7 regwrite=regdest=1.
REQ-031 Bench SHALL check opcode 111111 -> illegal=1 for exactly one cycle in DECODE, next state 0, retired unchanged; opcode 000010 behaves per MIPS_JUMP_EN.
REQ-032 Bench SHALL check wrap: RETIRE_W=4 with 16 R-type instructions -> retired returns to 0.
